audio_i2s_tx: RTL



---
 rtl/audio_i2s_tx.sv | 109 ++++++++++
 1 files changed

// File: rtl/audio_i2s_tx.sv
// I2S / left-justified serial transmitter: divides clk down to BCLK, frames
// one stereo pair per LRCK period and shifts it out MSB first.
module audio_i2s_tx #(
    parameter int IW       = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8,
    parameter int I2S_MODE = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [IW-1:0] snd_l_in,
    input  logic [IW-1:0] snd_r_in,
    output logic          sample_strobe,
    output logic          i2s_bclk,
    output logic          i2s_lrck,
    output logic          i2s_sdata
);

    localparam int FW = 2 * SLOT_W;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(FW);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] LOAD_BIT = BW'(I2S_MODE);
    localparam logic [BW-1:0] SLOT_BIT = BW'(SLOT_W);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [FW-1:0] shreg_q, shreg_d;
    logic          bclk_q, bclk_d;
    logic          lrck_q, lrck_d;
    logic          sdata_q, sdata_d;
    logic          strobe_q, strobe_d;

    logic [BW-1:0] bit_nxt;
    logic [FW-1:0] load_word;

    // Each channel word is left-aligned in its slot, padded with zeros below.
    assign load_word = (FW'(snd_l_in) << (FW - IW)) | (FW'(snd_r_in) << (SLOT_W - IW));

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        bclk_d    = bclk_q;
        lrck_d    = lrck_q;
        sdata_d   = sdata_q;
        strobe_d  = 1'b0;
        bit_nxt   = bit_cnt_q;

        if (!enable) begin
            div_cnt_d = '0;
            bit_cnt_d = BIT_LAST;
            shreg_d   = '0;
            bclk_d    = 1'b0;
            lrck_d    = 1'b0;
            sdata_d   = 1'b0;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end

            // Falling BCLK edge: every serial output moves together here.
            if (div_cnt_q == DIV_LAST && bclk_q) begin
                bit_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
                bit_cnt_d = bit_nxt;
                lrck_d    = (bit_nxt >= SLOT_BIT);
                if (bit_nxt == LOAD_BIT) begin
                    shreg_d  = load_word;
                    strobe_d = 1'b1;
                end else begin
                    shreg_d = shreg_q << 1;
                end
                sdata_d = shreg_d[FW-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= BIT_LAST;
            shreg_q   <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            bclk_q    <= bclk_d;
            lrck_q    <= lrck_d;
            sdata_q   <= sdata_d;
            strobe_q  <= strobe_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign i2s_bclk      = bclk_q;
    assign i2s_lrck      = lrck_q;
    assign i2s_sdata     = sdata_q;

endmodule
